// File: rtl/elevador_pkg.sv
// Shared types and defaults for the elevator car controller.
// Holds the FSM state encoding and the parameter defaults used by the RTL and the bench.
package elevador_pkg;

    localparam int FLOORS_DEF       = 4;
    localparam int FLOOR_W_DEF      = 2;
    localparam int TRAVEL_TICKS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE      = 2'd1,
        ST_DOOR_REQ  = 2'd2,
        ST_DOOR_WAIT = 2'd3
    } state_e;

    // The travel counter must be able to hold TRAVEL_TICKS-1; it is at least one bit wide.
    function automatic int cnt_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/elevador_scan.sv
// Combinational SCAN helper: reports whether calls are pending above, below or at a floor.
// The caller supplies any floor index; an index beyond the last floor yields no "here" call.
module elevador_scan
    import elevador_pkg::*;
#(
    parameter int FLOORS  = FLOORS_DEF,
    parameter int FLOOR_W = FLOOR_W_DEF
) (
    input  logic [FLOORS-1:0]  pending_i,
    input  logic [FLOOR_W-1:0] floor_i,
    output logic               any_above_o,
    output logic               any_below_o,
    output logic               here_o
);

    always_comb begin
        any_above_o = 1'b0;
        any_below_o = 1'b0;
        here_o      = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (FLOOR_W'(i) > floor_i) begin
                any_above_o = any_above_o | pending_i[i];
            end
            if (FLOOR_W'(i) < floor_i) begin
                any_below_o = any_below_o | pending_i[i];
            end
            if (FLOOR_W'(i) == floor_i) begin
                here_o = here_o | pending_i[i];
            end
        end
    end

endmodule

// File: rtl/elevador_ctrl.sv
// Elevator car controller: latches floor calls, picks direction with SCAN, steps floor by
// floor on tick pulses and hands each served floor to the door sequencer via start/done.
//
//   state        | meaning
//   ST_IDLE      | parked; choose between serving here, moving up or moving down
//   ST_MOVE      | travelling; counts ticks and steps one floor per TRAVEL_TICKS ticks
//   ST_DOOR_REQ  | one-cycle door_start pulse; clears the call at this floor
//   ST_DOOR_WAIT | doors cycling; waits for door_done
module elevador_ctrl
    import elevador_pkg::*;
#(
    parameter int FLOORS       = FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic [FLOORS-1:0]  call_req_i,
    input  logic               door_done_i,
    output logic               door_start_o,
    output logic [FLOOR_W-1:0] floor_o,
    output logic               dir_up_o,
    output logic               moving_o,
    output logic [FLOORS-1:0]  pending_o
);

    localparam int               CNT_W    = cnt_width(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TRAVEL_TICKS - 1);

    state_e             state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_up_q, dir_up_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FLOORS-1:0]  pending_q, pending_d;

    logic [FLOOR_W-1:0] floor_step;
    logic [FLOORS-1:0]  floor_oh;
    logic               in_door;
    logic               above_c, below_c, here_c;
    logic               above_n, below_n, here_n;

    assign floor_step = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
    assign in_door    = (state_q == ST_DOOR_REQ) || (state_q == ST_DOOR_WAIT);

    always_comb begin
        floor_oh = '0;
        for (int i = 0; i < FLOORS; i++) begin
            floor_oh[i] = (FLOOR_W'(i) == floor_q);
        end
    end

    // Current floor drives the IDLE decision; the next floor drives the MOVE arrival decision.
    elevador_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_cur (
        .pending_i   (pending_q),
        .floor_i     (floor_q),
        .any_above_o (above_c),
        .any_below_o (below_c),
        .here_o      (here_c)
    );

    elevador_scan #(
        .FLOORS  (FLOORS),
        .FLOOR_W (FLOOR_W)
    ) u_scan_nxt (
        .pending_i   (pending_q),
        .floor_i     (floor_step),
        .any_above_o (above_n),
        .any_below_o (below_n),
        .here_o      (here_n)
    );

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        pending_d = pending_q | (call_req_i & ~(in_door ? floor_oh : '0));

        case (state_q)
            ST_IDLE: begin
                if (here_c) begin
                    state_d = ST_DOOR_REQ;
                end else if (above_c && (dir_up_q || !below_c)) begin
                    dir_up_d = 1'b1;
                    state_d  = ST_MOVE;
                end else if (below_c) begin
                    dir_up_d = 1'b0;
                    state_d  = ST_MOVE;
                end
            end

            ST_MOVE: begin
                if (tick_i) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        floor_d = floor_step;
                        if (here_n) begin
                            state_d = ST_DOOR_REQ;
                        end else if (dir_up_q ? above_n : below_n) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DOOR_REQ: begin
                pending_d = pending_d & ~floor_oh;
                state_d   = ST_DOOR_WAIT;
            end

            ST_DOOR_WAIT: begin
                if (door_done_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    assign door_start_o = (state_q == ST_DOOR_REQ);
    assign moving_o     = (state_q == ST_MOVE);
    assign floor_o      = floor_q;
    assign dir_up_o     = dir_up_q;
    assign pending_o    = pending_q;

endmodule

// File: tb/tb_elevador_ctrl.sv
// Directed bench for elevador_ctrl with hand-computed expectations (FLOORS=4, TRAVEL_TICKS=8).
module tb_elevador_ctrl;
    import elevador_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       tick_i;
    logic [3:0] call_req_i;
    logic       door_done_i;
    logic       door_start_o;
    logic [1:0] floor_o;
    logic       dir_up_o;
    logic       moving_o;
    logic [3:0] pending_o;

    int n_checks = 0;
    int n_errors = 0;

    elevador_ctrl #(
        .FLOORS       (4),
        .FLOOR_W      (2),
        .TRAVEL_TICKS (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .tick_i       (tick_i),
        .call_req_i   (call_req_i),
        .door_done_i  (door_done_i),
        .door_start_o (door_start_o),
        .floor_o      (floor_o),
        .dir_up_o     (dir_up_o),
        .moving_o     (moving_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cyc(2);
        rst_i = 1'b0;
    endtask

    // Ends 1ns after the edge that sampled the last tick.
    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick_i = 1'b1;
            cyc(1);
            tick_i = 1'b0;
            if (i < n - 1) cyc(1);
        end
    endtask

    task automatic pulse_call(input logic [3:0] v);
        call_req_i = v;
        cyc(1);
        call_req_i = '0;
    endtask

    task automatic pulse_done();
        door_done_i = 1'b1;
        cyc(1);
        door_done_i = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds_seen;
        int cnt_bad;
        rst_i       = 1'b0;
        tick_i      = 1'b0;
        call_req_i  = '0;
        door_done_i = 1'b0;
        cyc(1);

        // Reset then idle, with ticks that must not advance the counter
        do_reset();
        check_eq("rst_floor",   floor_o,      0);
        check_eq("rst_dir",     dir_up_o,     1);
        check_eq("rst_pending", pending_o,    0);
        check_eq("rst_moving",  moving_o,     0);
        check_eq("rst_dstart",  door_start_o, 0);
        ds_seen = 0;
        cnt_bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick_i = 1'b1;
            cyc(1);
            tick_i = 1'b0;
            if (door_start_o) ds_seen++;
            if (dut.cnt_q != 0) cnt_bad++;
            cyc(1);
            if (door_start_o) ds_seen++;
        end
        check_eq("idle_no_dstart",  ds_seen, 0);
        check_eq("idle_tick_cnt",   cnt_bad, 0);
        check_eq("idle_moving",     moving_o, 0);

        // Local call at floor 0
        pulse_call(4'b0001);
        check_eq("local_latch",     pending_o,    4'b0001);
        check_eq("local_dstart_e1", door_start_o, 0);
        cyc(1);
        check_eq("local_dstart_e2", door_start_o, 1);
        cyc(1);
        check_eq("local_dstart_off", door_start_o, 0);
        check_eq("local_pend_clr",   pending_o,    0);
        check_eq("local_state_wait", dut.state_q,  ST_DOOR_WAIT);
        pulse_call(4'b0001);
        check_eq("wait_call_drop",   pending_o,    0);
        cyc(3);
        pulse_done();
        check_eq("local_back_idle",  dut.state_q,  ST_IDLE);
        check_eq("local_moving",     moving_o,     0);
        cyc(3);
        check_eq("local_no_restart", door_start_o, 0);
        check_eq("local_pend_end",   pending_o,    0);

        // Travel up 0 -> 2
        pulse_call(4'b0100);
        check_eq("up_latch",        pending_o, 4'b0100);
        check_eq("up_not_moving",   moving_o,  0);
        cyc(1);
        check_eq("up_moving",       moving_o,  1);
        check_eq("up_dir",          dir_up_o,  1);
        tick_n(7);
        check_eq("up_7ticks_floor", floor_o,   0);
        cyc(1);
        pulse_done();
        check_eq("move_done_ign",   dut.state_q, ST_MOVE);
        check_eq("move_done_mov",   moving_o,  1);
        tick_n(1);
        check_eq("up_8ticks_floor", floor_o,   1);
        check_eq("up_8ticks_mov",   moving_o,  1);
        tick_n(7);
        check_eq("up_15ticks_floor", floor_o,  1);
        tick_n(1);
        check_eq("up_16ticks_floor", floor_o,  2);
        check_eq("up_arrive_dstart", door_start_o, 1);
        check_eq("up_arrive_mov",    moving_o, 0);
        cyc(1);
        check_eq("up_pend_clr",      pending_o, 0);
        check_eq("up_dstart_off",    door_start_o, 0);
        pulse_done();
        check_eq("up_idle",          dut.state_q, ST_IDLE);

        // SCAN order: serve floor 3 before reversing to floor 0
        do_reset();
        pulse_call(4'b1000);
        cyc(1);
        check_eq("scan_moving", moving_o, 1);
        tick_n(8);
        check_eq("scan_floor1", floor_o, 1);
        pulse_call(4'b0001);
        check_eq("scan_pend",   pending_o, 4'b1001);
        tick_n(16);
        check_eq("scan_floor3",  floor_o,      3);
        check_eq("scan_ds3",     door_start_o, 1);
        check_eq("scan_dir3",    dir_up_o,     1);
        cyc(1);
        check_eq("scan_pend3",   pending_o,    4'b0001);
        pulse_done();
        check_eq("scan_idle3",   moving_o,     0);
        cyc(1);
        check_eq("scan_rev_mov", moving_o,     1);
        check_eq("scan_rev_dir", dir_up_o,     0);
        tick_n(16);
        check_eq("scan_pass1",   floor_o,      1);
        check_eq("scan_pass1_m", moving_o,     1);
        tick_n(8);
        check_eq("scan_floor0",  floor_o,      0);
        check_eq("scan_ds0",     door_start_o, 1);
        check_eq("scan_dir0",    dir_up_o,     0);
        cyc(1);
        check_eq("scan_pend0",   pending_o,    0);
        pulse_done();

        // Reset restores direction; then reset mid-move with a simultaneous call
        do_reset();
        check_eq("rst2_dir", dir_up_o, 1);
        pulse_call(4'b0100);
        cyc(1);
        tick_n(5);
        check_eq("mid_cnt5",   dut.cnt_q, 5);
        check_eq("mid_moving", moving_o,  1);
        rst_i      = 1'b1;
        call_req_i = 4'b0100;
        cyc(1);
        rst_i      = 1'b0;
        call_req_i = '0;
        check_eq("mid_rst_floor",   floor_o,      0);
        check_eq("mid_rst_moving",  moving_o,     0);
        check_eq("mid_rst_pending", pending_o,    0);
        check_eq("mid_rst_dstart",  door_start_o, 0);
        check_eq("mid_rst_cnt",     dut.cnt_q,    0);
        ds_seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (door_start_o || moving_o) ds_seen++;
        end
        check_eq("mid_rst_quiet", ds_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
